// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared slot type, default widths and latency classes for the hazard scoreboard.
package hazard_pkg;
  localparam int SLOT_REG_BITS = 5;
  localparam int DEF_DEPTH = 4;
  localparam int SLOT_LAT_BITS = $clog2(DEF_DEPTH + 1);
  localparam int FWD_REGFILE = 0;
  localparam int LAT_ALU = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MULDIV = DEF_DEPTH;
  typedef struct packed {
    logic valid;
    logic [SLOT_REG_BITS-1:0] rd;
    logic [SLOT_LAT_BITS-1:0] lat;
  } slot_t;
endpackage

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: youngest in-flight writer of one source register and whether its result is still unavailable.
module hazard_match import hazard_pkg::*; #(
  parameter int REG_BITS = SLOT_REG_BITS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT_BITS = SLOT_LAT_BITS
) (
  input  slot_t               slots [DEPTH],
  input  logic [REG_BITS-1:0] r,
  output logic                hit,
  output logic [LAT_BITS-1:0] idx,
  output logic                hazard
);
  logic [LAT_BITS-1:0] lat_m;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    lat_m = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (slots[i].valid && slots[i].rd == r && r != '0) begin
        hit = 1'b1;
        idx = LAT_BITS'(i);
        lat_m = slots[i].lat;
      end
    hazard = hit && ((idx + LAT_BITS'(1)) < lat_m);
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writes, stalls decode on unready operands and issues forwarding selects.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int REG_BITS = SLOT_REG_BITS,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LAT_BITS = SLOT_LAT_BITS,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 id_valid,
  input  logic [REG_BITS-1:0]  id_rs1,
  input  logic [REG_BITS-1:0]  id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_BITS-1:0]  id_rd,
  input  logic                 id_rd_wr,
  input  logic [LAT_BITS-1:0]  id_lat,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [LAT_BITS-1:0]  fwd_a,
  output logic [LAT_BITS-1:0]  fwd_b,
  output logic [CNT_WIDTH-1:0] stall_cnt
);
  slot_t slots [DEPTH];
  logic hit1, hit2, hz1, hz2, issue;
  logic [LAT_BITS-1:0] idx1, idx2, lat_c;
  hazard_match #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .LAT_BITS(LAT_BITS)) u_m1 (
    .slots(slots), .r(id_rs1), .hit(hit1), .idx(idx1), .hazard(hz1)
  );
  hazard_match #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .LAT_BITS(LAT_BITS)) u_m2 (
    .slots(slots), .r(id_rs2), .hit(hit2), .idx(idx2), .hazard(hz2)
  );
  always_comb begin
    stall = id_valid && !flush && ((id_rs1_used && hz1) || (id_rs2_used && hz2));
    issue = id_valid && !stall && !flush;
    lat_c = (id_lat == '0) ? LAT_BITS'(1) : (id_lat > LAT_BITS'(DEPTH)) ? LAT_BITS'(DEPTH) : id_lat;
  end
  // slot i holds the producer that sits in stage i+1 during the next cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      ex_valid <= 1'b0;
      fwd_a <= LAT_BITS'(FWD_REGFILE);
      fwd_b <= LAT_BITS'(FWD_REGFILE);
      stall_cnt <= '0;
    end else begin
      slots[0] <= (issue && id_rd_wr && id_rd != '0) ? '{1'b1, id_rd, lat_c} : '0;
      for (int i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
      ex_valid <= issue;
      fwd_a <= (issue && id_rs1_used && hit1) ? idx1 + LAT_BITS'(1) : LAT_BITS'(FWD_REGFILE);
      fwd_b <= (issue && id_rs2_used && hit2) ? idx2 + LAT_BITS'(1) : LAT_BITS'(FWD_REGFILE);
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end
  a_lat_range: assert property (@(posedge clk) disable iff (!rstn)
    !(id_valid && id_rd_wr && id_lat > LAT_BITS'(DEPTH)));
endmodule
